// File: rtl/ps2_player_input_if.sv
// Player-control bundle produced by the PS/2 receiver: key levels, last scan code and status pulses.
// The receiver drives the bundle through master; the game top level reads it through slave.
interface ps2_player_input_if;
    logic [3:0] player_1_move_o;
    logic [3:0] player_2_move_o;
    logic       player_1_shoot_o;
    logic       player_2_shoot_o;
    logic [7:0] scan_code_o;
    logic       scan_valid_o;
    logic       frame_error_o;

    modport master (
        output player_1_move_o, player_2_move_o, player_1_shoot_o, player_2_shoot_o,
               scan_code_o, scan_valid_o, frame_error_o
    );
    modport slave (
        input  player_1_move_o, player_2_move_o, player_1_shoot_o, player_2_shoot_o,
               scan_code_o, scan_valid_o, frame_error_o
    );
endinterface

// File: rtl/ps2_player_input.sv
// PS/2 keyboard receiver with E0/F0 prefix decoding into held-key levels for both tank players.
// Single clk_i domain; ps2 lines are synchronised, and ps2_clk is deglitched before edge detection.
module ps2_player_input #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       ps2_clk_i,
    input  logic                       ps2_data_i,
    ps2_player_input_if.master         player_if
);

    localparam int FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_e;

    // Synchronisers idle high so reset release never looks like a start edge.
    logic              clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic              clk_filt_q;
    logic [FILT_W-1:0] filt_cnt_q;
    logic              filt_accept, strobe;

    // NOTE: every clocked register uses <= so all flops see pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk_i;
            clk_s2_q  <= clk_s1_q;
            data_s1_q <= ps2_data_i;
            data_s2_q <= data_s1_q;
        end
    end

    assign filt_accept = (clk_s2_q != clk_filt_q) && (filt_cnt_q == FILT_W'(FILTER_LEN - 1));
    assign strobe      = filt_accept && clk_filt_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            clk_filt_q <= 1'b1;
            filt_cnt_q <= '0;
        end else if (clk_s2_q == clk_filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_accept) begin
            clk_filt_q <= clk_s2_q;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
        end
    end

    rx_state_e       state_q;
    logic [7:0]      shift_q;
    logic [2:0]      bit_cnt_q;
    logic            parity_q;
    logic [TO_W-1:0] timeout_q;
    logic [7:0]      scan_code_q;
    logic            scan_valid_q, frame_error_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q       <= S_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            parity_q      <= 1'b0;
            timeout_q     <= '0;
            scan_code_q   <= '0;
            scan_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            scan_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            if (state_q == S_IDLE || strobe) begin
                timeout_q <= '0;
            end else if (timeout_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                // Partial frame abandoned; any pending prefix flags survive in the decoder.
                state_q   <= S_IDLE;
                timeout_q <= '0;
            end else begin
                timeout_q <= timeout_q + 1'b1;
            end

            if (strobe) begin
                unique case (state_q)
                    S_IDLE: begin
                        bit_cnt_q <= '0;
                        if (!data_s2_q) state_q <= S_DATA;
                    end
                    S_DATA: begin
                        shift_q   <= {data_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
                    end
                    S_PARITY: begin
                        parity_q <= data_s2_q;
                        state_q  <= S_STOP;
                    end
                    S_STOP: begin
                        if (data_s2_q && (^{shift_q, parity_q})) begin
                            scan_valid_q <= 1'b1;
                            scan_code_q  <= shift_q;
                        end else begin
                            frame_error_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    logic [3:0] p1_move_q, p1_move_d, p2_move_q, p2_move_d;
    logic       p1_shoot_q, p1_shoot_d, p2_shoot_q, p2_shoot_d;
    logic       ext_q, ext_d, brk_q, brk_d;

    // NOTE: each always_comb output is given a default first so no path leaves it unassigned (no latch).
    always_comb begin
        p1_move_d  = p1_move_q;
        p2_move_d  = p2_move_q;
        p1_shoot_d = p1_shoot_q;
        p2_shoot_d = p2_shoot_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        if (scan_valid_q) begin
            unique case (scan_code_q)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                default: begin
                    if (!ext_q) begin
                        case (scan_code_q)
                            8'h1B: p1_move_d[0] = ~brk_q;
                            8'h1D: p1_move_d[1] = ~brk_q;
                            8'h1C: p1_move_d[2] = ~brk_q;
                            8'h23: p1_move_d[3] = ~brk_q;
                            8'h29: p1_shoot_d   = ~brk_q;
                            8'h5A: p2_shoot_d   = ~brk_q;
                            default: ;
                        endcase
                    end else begin
                        case (scan_code_q)
                            8'h72: p2_move_d[0] = ~brk_q;
                            8'h75: p2_move_d[1] = ~brk_q;
                            8'h6B: p2_move_d[2] = ~brk_q;
                            8'h74: p2_move_d[3] = ~brk_q;
                            default: ;
                        endcase
                    end
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            p1_move_q  <= '0;
            p2_move_q  <= '0;
            p1_shoot_q <= 1'b0;
            p2_shoot_q <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            p1_move_q  <= p1_move_d;
            p2_move_q  <= p2_move_d;
            p1_shoot_q <= p1_shoot_d;
            p2_shoot_q <= p2_shoot_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
        end
    end

    assign player_if.player_1_move_o  = p1_move_q;
    assign player_if.player_2_move_o  = p2_move_q;
    assign player_if.player_1_shoot_o = p1_shoot_q;
    assign player_if.player_2_shoot_o = p2_shoot_q;
    assign player_if.scan_code_o      = scan_code_q;
    assign player_if.scan_valid_o     = scan_valid_q;
    assign player_if.frame_error_o    = frame_error_q;

endmodule

// File: tb/tb_ps2_player_input.sv
// Directed bench for ps2_player_input: bit-bangs PS/2 frames and checks key levels and pulses.
`timescale 1ns/1ps
module tb_ps2_player_input;

    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int HALF           = 10;

    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   valid_cnt = 0;
    int   err_cnt = 0;

    ps2_player_input_if bus ();

    ps2_player_input #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_i      (clk),
        .reset_ni   (reset_ni),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .player_if  (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.scan_valid_o) valid_cnt++;
        if (bus.frame_error_o) err_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one bit; glitch pulses ps2_clk low for FILTER_LEN-1 cycles during the high phase.
    task automatic send_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            wait_cyc(2);
            ps2_clk = 1'b0;
            wait_cyc(FILTER_LEN - 1);
            ps2_clk = 1'b1;
            wait_cyc(HALF);
        end else begin
            wait_cyc(HALF);
        end
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_parity, input bit glitch);
        logic par;
        par = ~(^b) ^ bad_parity;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch && (i == 4));
        send_bit(par, 1'b0);
        send_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        wait_cyc(3 * HALF);
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        send_frame(8'h1D, 1'b0, 1'b0);
        send_frame(8'h29, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0);
        tests_run++;
        if (valid_cnt !== 0 || err_cnt !== 0) begin
            tests_failed++;
            $display("FAIL reset_pulses: valid=%0d err=%0d required 0/0", valid_cnt, err_cnt);
        end
        tests_run++;
        if ({bus.player_1_move_o, bus.player_2_move_o, bus.player_1_shoot_o,
             bus.player_2_shoot_o, bus.scan_code_o} !== 18'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: p1=%b p2=%b s1=%b s2=%b code=%h required all 0",
                     bus.player_1_move_o, bus.player_2_move_o, bus.player_1_shoot_o,
                     bus.player_2_shoot_o, bus.scan_code_o);
        end
        reset_ni = 1'b1;
        wait_cyc(5);
    endtask

    task automatic test_p1_up();
        int v0 = valid_cnt;
        send_frame(8'h1D, 1'b0, 1'b0);
        tests_run++;
        if (valid_cnt - v0 !== 1) begin
            tests_failed++;
            $display("FAIL p1_valid_count: got %0d required 1", valid_cnt - v0);
        end
        tests_run++;
        if (bus.scan_code_o !== 8'h1D) begin
            tests_failed++;
            $display("FAIL p1_scan_code: got %h required 1d", bus.scan_code_o);
        end
        tests_run++;
        if (bus.player_1_move_o !== 4'b0010) begin
            tests_failed++;
            $display("FAIL p1_make: got %b required 0010", bus.player_1_move_o);
        end
        send_frame(8'h1D, 1'b0, 1'b0);
        tests_run++;
        if (bus.player_1_move_o !== 4'b0010) begin
            tests_failed++;
            $display("FAIL p1_typematic: got %b required 0010", bus.player_1_move_o);
        end
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0);
        tests_run++;
        if (bus.player_1_move_o !== 4'b0000) begin
            tests_failed++;
            $display("FAIL p1_break: got %b required 0000", bus.player_1_move_o);
        end
    endtask

    task automatic test_p2_extended();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        tests_run++;
        if (bus.player_2_move_o !== 4'b0010) begin
            tests_failed++;
            $display("FAIL p2_make: got %b required 0010", bus.player_2_move_o);
        end
        send_frame(8'h75, 1'b0, 1'b0);
        tests_run++;
        if (bus.player_2_move_o !== 4'b0010 || bus.scan_code_o !== 8'h75) begin
            tests_failed++;
            $display("FAIL p2_keypad_ignored: got %b/%h required 0010/75",
                     bus.player_2_move_o, bus.scan_code_o);
        end
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0);
        tests_run++;
        if (bus.player_1_move_o !== 4'b0000) begin
            tests_failed++;
            $display("FAIL ext_1d_ignored: got %b required 0000", bus.player_1_move_o);
        end
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        tests_run++;
        if (bus.player_2_move_o !== 4'b0000) begin
            tests_failed++;
            $display("FAIL p2_break: got %b required 0000", bus.player_2_move_o);
        end
    endtask

    task automatic test_parity_error();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        send_frame(8'h29, 1'b1, 1'b0);
        tests_run++;
        if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin
            tests_failed++;
            $display("FAIL parity_pulses: err=%0d valid=%0d required 1/0", err_cnt - e0, valid_cnt - v0);
        end
        tests_run++;
        if (bus.player_1_shoot_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL parity_no_shoot: got %b required 0", bus.player_1_shoot_o);
        end
        send_frame(8'h29, 1'b0, 1'b0);
        tests_run++;
        if (bus.player_1_shoot_o !== 1'b1 || bus.scan_code_o !== 8'h29) begin
            tests_failed++;
            $display("FAIL good_shoot: got %b/%h required 1/29", bus.player_1_shoot_o, bus.scan_code_o);
        end
    endtask

    task automatic test_timeout();
        int v0;
        int e0;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        wait_cyc(TIMEOUT_CYCLES + 10);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h5A, 1'b0, 1'b0);
        tests_run++;
        if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin
            tests_failed++;
            $display("FAIL timeout_pulses: valid=%0d err=%0d required 1/0", valid_cnt - v0, err_cnt - e0);
        end
        tests_run++;
        if (bus.player_2_shoot_o !== 1'b1 || bus.scan_code_o !== 8'h5A) begin
            tests_failed++;
            $display("FAIL timeout_recover: got %b/%h required 1/5a", bus.player_2_shoot_o, bus.scan_code_o);
        end
    endtask

    task automatic test_glitch();
        int e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1);
        tests_run++;
        if (bus.scan_code_o !== 8'h1C || err_cnt !== e0) begin
            tests_failed++;
            $display("FAIL glitch_code: got %h err=%0d required 1c err=0", bus.scan_code_o, err_cnt - e0);
        end
        tests_run++;
        if (bus.player_1_move_o !== 4'b0100) begin
            tests_failed++;
            $display("FAIL glitch_left: got %b required 0100", bus.player_1_move_o);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h23, 1'b0, 1'b0);
        send_frame(8'h1B, 1'b0, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b0);
        send_frame(8'h23, 1'b0, 1'b0);
        tests_run++;
        if (bus.player_1_move_o !== 4'b1101) begin
            tests_failed++;
            $display("FAIL back_to_back: got %b required 1101", bus.player_1_move_o);
        end
    endtask

    initial begin
        wait_cyc(3);
        test_reset();
        test_p1_up();
        test_p2_extended();
        test_parity_error();
        test_timeout();
        test_glitch();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
